// File: rtl/alu_pkg.sv
// Shared definitions for the vector ALU sequencer: op encoding, FSM states
// and the legality check used at operation acceptance.
package alu_pkg;

    // ALU operation encoding; 3'b000 and 3'b111 are deliberately unused.
    typedef enum logic [2:0] {
        OP_XOR = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_MUL = 3'b100,
        OP_SHR = 3'b101,
        OP_SHL = 3'b110
    } op_e;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // True for every op code that maps to a real ALU operation.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != 3'b000) && (op != 3'b111);
    endfunction

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// Request/response bundle between a vector-op producer and the sequencer.
interface vector_alu_sequencer_if #(
    parameter int dataSize = 8,
    parameter int lanes    = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [2:0]                  op;
    logic [lanes*dataSize-1:0]   vec_a;
    logic [lanes*dataSize-1:0]   vec_b;
    logic                        out_valid;
    logic                        out_ready;
    logic [lanes*dataSize-1:0]   vec_r;
    logic                        neg_any;
    logic                        zero_all;
    logic                        illegal_op;

    // Producer / consumer side.
    modport master (
        output in_valid, op, vec_a, vec_b, out_ready,
        input  in_ready, out_valid, vec_r, neg_any, zero_all, illegal_op
    );

    // Sequencer side.
    modport slave (
        input  in_valid, op, vec_a, vec_b, out_ready,
        output in_ready, out_valid, vec_r, neg_any, zero_all, illegal_op
    );
endinterface

// File: rtl/alu.sv
// Combinational single-element ALU. Results wrap to dataSize bits; the shift
// ops use operand2 as the shift distance.
module alu
    import alu_pkg::*;
#(
    parameter int dataSize = 8
) (
    input  logic [2:0]          operation_select,
    input  logic [dataSize-1:0] operand1,
    input  logic [dataSize-1:0] operand2,
    output logic [dataSize-1:0] result,
    output logic                neg_flag,
    output logic                zero_flag
);

    // Select the element result; unused codes produce zero.
    always_comb begin
        result = '0;
        case (operation_select)
            OP_XOR:  result = operand1 ^ operand2;
            OP_ADD:  result = operand1 + operand2;
            OP_SUB:  result = operand1 - operand2;
            OP_MUL:  result = operand1 * operand2;
            OP_SHR:  result = operand1 >> operand2;
            OP_SHL:  result = operand1 << operand2;
            default: result = '0;
        endcase
    end

    assign neg_flag  = result[dataSize-1];
    assign zero_flag = (result == '0);

endmodule

// File: rtl/vector_alu_sequencer.sv
// Sequences one scalar ALU across all lanes of a vector operation, one lane
// per cycle, and presents the packed result with aggregated flags.
module vector_alu_sequencer
    import alu_pkg::*;
#(
    parameter int dataSize = 8,
    parameter int lanes    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vector_alu_sequencer_if.slave bus
);

    localparam int            IDX_W    = $clog2(lanes);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(lanes - 1);

    state_e                    r_state;
    state_e                    w_state_next;
    logic                      r_ready_en;
    logic [2:0]                r_op;
    logic [lanes*dataSize-1:0] r_vec_a;
    logic [lanes*dataSize-1:0] r_vec_b;
    logic [lanes*dataSize-1:0] r_vec_r;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_neg_any;
    logic                      r_zero_all;
    logic                      r_illegal_op;
    logic                      r_out_valid;

    logic                      w_in_ready;
    logic                      w_accept;
    logic [dataSize-1:0]       w_elem_a [lanes];
    logic [dataSize-1:0]       w_elem_b [lanes];
    logic [dataSize-1:0]       w_operand1;
    logic [dataSize-1:0]       w_operand2;
    logic [dataSize-1:0]       w_result;
    logic                      w_neg_flag;
    logic                      w_zero_flag;

    // Unpack the captured operand vectors into per-lane elements.
    for (genvar gi = 0; gi < lanes; gi++) begin : g_unpack
        assign w_elem_a[gi] = r_vec_a[gi*dataSize +: dataSize];
        assign w_elem_b[gi] = r_vec_b[gi*dataSize +: dataSize];
    end

    assign w_operand1 = w_elem_a[r_idx];
    assign w_operand2 = w_elem_b[r_idx];

    alu #(
        .dataSize (dataSize)
    ) u_alu (
        .operation_select (r_op),
        .operand1         (w_operand1),
        .operand2         (w_operand2),
        .result           (w_result),
        .neg_flag         (w_neg_flag),
        .zero_flag        (w_zero_flag)
    );

    // State register; reset forces IDLE without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and ready decode. Ready stays low until the first edge after
    // reset release; illegal ops skip RUN entirely. DONE only completes once
    // out_valid has actually been presented.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = r_ready_en;
                if (bus.in_valid && r_ready_en) begin
                    w_state_next = is_legal_op(bus.op) ? RUN : DONE;
                end
            end
            RUN: begin
                if (r_idx == IDX_LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_accept = w_in_ready && bus.in_valid;

    // Operand capture, per-lane result write-back, flag accumulation and
    // the registered out_valid (asserted one cycle after entering DONE).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready_en   <= 1'b0;
            r_op         <= 3'b000;
            r_vec_a      <= '0;
            r_vec_b      <= '0;
            r_vec_r      <= '0;
            r_idx        <= '0;
            r_neg_any    <= 1'b0;
            r_zero_all   <= 1'b0;
            r_illegal_op <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                IDLE: begin
                    r_out_valid <= 1'b0;
                    if (w_accept) begin
                        r_op    <= bus.op;
                        r_vec_a <= bus.vec_a;
                        r_vec_b <= bus.vec_b;
                        r_vec_r <= '0;
                        r_idx   <= '0;
                        if (is_legal_op(bus.op)) begin
                            r_illegal_op <= 1'b0;
                            r_neg_any    <= 1'b0;
                            r_zero_all   <= 1'b1;
                        end else begin
                            r_illegal_op <= 1'b1;
                            r_neg_any    <= 1'b0;
                            r_zero_all   <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    r_out_valid <= 1'b0;
                    r_vec_r[r_idx*dataSize +: dataSize] <= w_result;
                    r_neg_any  <= r_neg_any | w_neg_flag;
                    r_zero_all <= r_zero_all & w_zero_flag;
                    if (r_idx != IDX_LAST) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_out_valid <= !(r_out_valid && bus.out_ready);
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.vec_r      = r_vec_r;
    assign bus.neg_any    = r_neg_any;
    assign bus.zero_all   = r_zero_all;
    assign bus.illegal_op = r_illegal_op;

endmodule
